// File: rtl/crossbar_2x2_sched_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_2x2_sched_pkg
//   Shared constants and types for the 2x2 crossbar scheduler.
//   - XBAR_STRAIGHT / XBAR_CROSS : encoding of the crossbar control bit
//   - DEST_OUT1 / DEST_OUT2      : encoding of a requester's destination bit
//   - rr_state_e                 : round-robin pointer state (which requester
//                                  wins the next output conflict)
//   - slot_ok()                  : picks the "can accept" flag of the slot a
//                                  destination bit points at
// ---------------------------------------------------------------------------
package crossbar_2x2_sched_pkg;

    localparam logic XBAR_STRAIGHT = 1'b0;
    localparam logic XBAR_CROSS    = 1'b1;
    localparam logic DEST_OUT1     = 1'b0;
    localparam logic DEST_OUT2     = 1'b1;

    typedef enum logic {
        RR_IN1 = 1'b0,
        RR_IN2 = 1'b1
    } rr_state_e;

    // slot_can[0] belongs to out1, slot_can[1] to out2.
    function automatic logic slot_ok(input logic dest, input logic [1:0] slot_can);
        return (dest == DEST_OUT2) ? slot_can[1] : slot_can[0];
    endfunction

endpackage

// File: rtl/crossbar_2x2_sched_arb.sv
// ---------------------------------------------------------------------------
// xbar_rr_arb
//   Conflict detection, round-robin pointer and combinational grant logic
//   for the 2x2 crossbar scheduler.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in1_valid, in1_dest   requester 1 request and target (0 = out1, 1 = out2)
//     in2_valid, in2_dest   requester 2 request and target
//     slot_can[1:0]         output slot can take a word this cycle
//                           ([0] = out1, [1] = out2)
//     grant1, grant2        combinational grants (used directly as in*_ready)
//     conflict              both requesters valid with the same target
//
//   Handshake: a requester's word moves on a rising edge where its valid and
//   its grant are both high. Grants are only raised for valid requesters, so
//   grant alone marks a transfer; ready may therefore depend on valid.
// ---------------------------------------------------------------------------
module xbar_rr_arb
    import crossbar_2x2_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1_valid,
    input  logic       in1_dest,
    input  logic       in2_valid,
    input  logic       in2_dest,
    input  logic [1:0] slot_can,
    output logic       grant1,
    output logic       grant2,
    output logic       conflict
);

    rr_state_e rr_q;
    rr_state_e rr_d;

    logic ok1;
    logic ok2;

    always_comb begin
        ok1      = slot_ok(in1_dest, slot_can);
        ok2      = slot_ok(in2_dest, slot_can);
        conflict = in1_valid && in2_valid && (in1_dest == in2_dest);

        grant1 = 1'b0;
        grant2 = 1'b0;
        if (conflict) begin
            // Only the pointed-at requester is considered; the loser waits
            // even if the slot could take a word.
            grant1 = (rr_q == RR_IN1) && ok1;
            grant2 = (rr_q == RR_IN2) && ok2;
        end else begin
            grant1 = in1_valid && ok1;
            grant2 = in2_valid && ok2;
        end

        // Nothing is accepted while reset is held, even though the output
        // slots look empty then.
        if (!rst_n) begin
            grant1 = 1'b0;
            grant2 = 1'b0;
        end
    end

    // The pointer only moves when a conflict winner actually transfers; a
    // conflict stalled by a full slot keeps the same winner queued up.
    always_comb begin
        rr_d = rr_q;
        if (conflict && (grant1 || grant2)) begin
            rr_d = (rr_q == RR_IN1) ? RR_IN2 : RR_IN1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_IN1;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/crossbar_2x2_sched_dp.sv
// ---------------------------------------------------------------------------
// xbar_2x2_dp
//   The 2x2 crossbar datapath: a pair of word multiplexers steered by one
//   control bit.
//
//   Ports:
//     ctrl          XBAR_STRAIGHT: a_out = a_in, b_out = b_in
//                   XBAR_CROSS   : a_out = b_in, b_out = a_in
//     a_in, b_in    input words (requester 1, requester 2)
//     a_out, b_out  output words (towards out1, out2)
// ---------------------------------------------------------------------------
module xbar_2x2_dp
    import crossbar_2x2_sched_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              ctrl,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    always_comb begin
        if (ctrl == XBAR_CROSS) begin
            a_out = b_in;
            b_out = a_in;
        end else begin
            a_out = a_in;
            b_out = b_in;
        end
    end

endmodule

// File: rtl/crossbar_2x2_sched.sv
// ---------------------------------------------------------------------------
// crossbar_2x2_sched
//   Scheduler and output stage of the 2x2 crossbar. Two requesters offer
//   DATA_W-bit words with a destination bit; the block grants them, steers
//   the crossbar datapath and captures each word into a 1-deep output
//   register per destination with ready backpressure.
//
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     in1_valid/in1_data/in1_dest     requester 1 word (dest 0 = out1, 1 = out2)
//     in1_ready                       requester 1 word accepted this cycle
//     in2_valid/in2_data/in2_dest     requester 2 word
//     in2_ready                       requester 2 word accepted this cycle
//     out1_valid/out1_data            output 1 register
//     out1_ready                      consumer 1 takes the word
//     out2_valid/out2_data            output 2 register
//     out2_ready                      consumer 2 takes the word
//     xbar_ctrl                       control of the last accepting cycle
//                                     (0 = straight, 1 = cross)
//     conflict_cnt [CNT_W-1:0]        saturating count of conflict cycles,
//                                     present only when CROSSBAR_STATS_EN
//                                     is defined
//
//   Handshake (all four ports): a word moves on a rising edge where valid
//   and ready are both high. in*_ready is the combinational grant and may
//   depend on in*_valid; out*_valid never depends on out*_ready.
//
//   Build option: define CROSSBAR_STATS_EN to add the conflict counter.
// ---------------------------------------------------------------------------
module crossbar_2x2_sched
    import crossbar_2x2_sched_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_dest,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_dest,
    output logic              in2_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic              out2_valid,
    output logic [DATA_W-1:0] out2_data,
    input  logic              out2_ready,
`ifdef CROSSBAR_STATS_EN
    output logic [CNT_W-1:0]  conflict_cnt,
`endif
    output logic              xbar_ctrl
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("crossbar_2x2_sched: DATA_W and CNT_W must be at least 1");
    end

    // ---------------- state ----------------
    logic              out1_valid_q, out1_valid_d;
    logic              out2_valid_q, out2_valid_d;
    logic [DATA_W-1:0] out1_data_q,  out1_data_d;
    logic [DATA_W-1:0] out2_data_q,  out2_data_d;
    logic              xbar_ctrl_q,  xbar_ctrl_d;

    // ---------------- scheduling ----------------
    logic [1:0]        slot_can;
    logic              grant1;
    logic              grant2;
    logic              conflict;
    logic              ctrl;
    logic              load1;
    logic              load2;
    logic [DATA_W-1:0] dp_out1;
    logic [DATA_W-1:0] dp_out2;

    // A slot can take a word when empty or when it drains on the same edge.
    always_comb begin
        slot_can[0] = !out1_valid_q || out1_ready;
        slot_can[1] = !out2_valid_q || out2_ready;
    end

    xbar_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_valid (in1_valid),
        .in1_dest  (in1_dest),
        .in2_valid (in2_valid),
        .in2_dest  (in2_dest),
        .slot_can  (slot_can),
        .grant1    (grant1),
        .grant2    (grant2),
        .conflict  (conflict)
    );

    assign in1_ready = grant1;
    assign in2_ready = grant2;

    // Requester 1 steers whenever it is granted; if only requester 2 moves,
    // the crossbar is set so that its word lands on its destination. When
    // both are granted their destinations differ, so both views agree.
    always_comb begin
        ctrl = xbar_ctrl_q;
        if (grant1) begin
            ctrl = in1_dest;
        end else if (grant2) begin
            ctrl = ~in2_dest;
        end
    end

    xbar_2x2_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .ctrl  (ctrl),
        .a_in  (in1_data),
        .b_in  (in2_data),
        .a_out (dp_out1),
        .b_out (dp_out2)
    );

    always_comb begin
        load1 = (grant1 && (in1_dest == DEST_OUT1)) || (grant2 && (in2_dest == DEST_OUT1));
        load2 = (grant1 && (in1_dest == DEST_OUT2)) || (grant2 && (in2_dest == DEST_OUT2));
    end

    // ---------------- output registers ----------------
    always_comb begin
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        if (load1) begin
            out1_valid_d = 1'b1;
            out1_data_d  = dp_out1;
        end else if (out1_ready) begin
            out1_valid_d = 1'b0;
        end

        out2_valid_d = out2_valid_q;
        out2_data_d  = out2_data_q;
        if (load2) begin
            out2_valid_d = 1'b1;
            out2_data_d  = dp_out2;
        end else if (out2_ready) begin
            out2_valid_d = 1'b0;
        end

        xbar_ctrl_d = (grant1 || grant2) ? ctrl : xbar_ctrl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_valid_q <= 1'b0;
            out2_valid_q <= 1'b0;
            out1_data_q  <= '0;
            out2_data_q  <= '0;
            xbar_ctrl_q  <= XBAR_STRAIGHT;
        end else begin
            out1_valid_q <= out1_valid_d;
            out2_valid_q <= out2_valid_d;
            out1_data_q  <= out1_data_d;
            out2_data_q  <= out2_data_d;
            xbar_ctrl_q  <= xbar_ctrl_d;
        end
    end

    assign out1_valid = out1_valid_q;
    assign out2_valid = out2_valid_q;
    assign out1_data  = out1_data_q;
    assign out2_data  = out2_data_q;
    assign xbar_ctrl  = xbar_ctrl_q;

`ifdef CROSSBAR_STATS_EN
    // ---------------- conflict statistics ----------------
    // Counts every conflict cycle, whether or not the winner could move.
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
// ---------------------------------------------------------------------------
// tb_crossbar_2x2_sched
//   Directed bench for crossbar_2x2_sched. A reference model of the two
//   output slots, the round-robin winner and the steering bit is checked
//   against the DUT on every falling edge; the directed sequence adds
//   hand-computed literal checks at the interesting points.
// ---------------------------------------------------------------------------
module tb_crossbar_2x2_sched;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              in1_valid, in2_valid;
    logic [DATA_W-1:0] in1_data,  in2_data;
    logic              in1_dest,  in2_dest;
    logic              in1_ready, in2_ready;
    logic              out1_valid, out2_valid;
    logic [DATA_W-1:0] out1_data,  out2_data;
    logic              out1_ready, out2_ready;
    logic              xbar_ctrl;
`ifdef CROSSBAR_STATS_EN
    logic [CNT_W-1:0]  conflict_cnt;
`endif

    crossbar_2x2_sched #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1_valid    (in1_valid),
        .in1_data     (in1_data),
        .in1_dest     (in1_dest),
        .in1_ready    (in1_ready),
        .in2_valid    (in2_valid),
        .in2_data     (in2_data),
        .in2_dest     (in2_dest),
        .in2_ready    (in2_ready),
        .out1_valid   (out1_valid),
        .out1_data    (out1_data),
        .out1_ready   (out1_ready),
        .out2_valid   (out2_valid),
        .out2_data    (out2_data),
        .out2_ready   (out2_ready),
`ifdef CROSSBAR_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .xbar_ctrl    (xbar_ctrl)
    );

    // ---------------- bookkeeping ----------------
    int  n_total = 0;
    int  n_pass  = 0;
    bit  done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Two slots indexed by destination, two requesters indexed 0/1.
    bit              m_full[2];
    logic [DATA_W-1:0] m_data[2];
    bit              m_rr;      // 0: requester 1 wins next conflict
    bit              m_ctrl;
    int              m_cnt;

    initial begin : model
        bit              v[2];
        bit              d[2];
        logic [DATA_W-1:0] w[2];
        bit              ordy[2];
        bit              eg[2];
        bit              conf;
        bit              pend;
        m_full = '{0, 0};
        m_data = '{'0, '0};
        m_rr   = 0;
        m_ctrl = 0;
        m_cnt  = 0;
        pend   = 0;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            pend = 0;
            if (!rst_n) begin
                m_full = '{0, 0};
                m_data = '{'0, '0};
                m_rr   = 0;
                m_ctrl = 0;
                m_cnt  = 0;
                check("m_rst_in1_ready", in1_ready, 0);
                check("m_rst_in2_ready", in2_ready, 0);
            end else begin
                v    = '{in1_valid, in2_valid};
                d    = '{in1_dest, in2_dest};
                w    = '{in1_data, in2_data};
                ordy = '{out1_ready, out2_ready};
                conf = v[0] && v[1] && (d[0] == d[1]);
                for (int i = 0; i < 2; i++) begin
                    eg[i] = v[i] && (!m_full[d[i]] || ordy[d[i]]);
                end
                if (conf) eg[m_rr ? 0 : 1] = 0;
                check("m_in1_ready", in1_ready, eg[0]);
                check("m_in2_ready", in2_ready, eg[1]);
                pend = 1;
            end
            check("m_out1_valid", out1_valid, m_full[0]);
            check("m_out2_valid", out2_valid, m_full[1]);
            check("m_out1_data", out1_data, m_data[0]);
            check("m_out2_data", out2_data, m_data[1]);
            check("m_xbar_ctrl", xbar_ctrl, m_ctrl);
`ifdef CROSSBAR_STATS_EN
            check("m_conflict_cnt", conflict_cnt, m_cnt);
`endif
            @(posedge clk);
            if (pend && rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_full[k] && ordy[k]) m_full[k] = 0;
                end
                for (int i = 0; i < 2; i++) begin
                    if (eg[i]) begin
                        m_full[d[i]] = 1;
                        m_data[d[i]] = w[i];
                    end
                end
                if (conf && (eg[0] || eg[1])) m_rr = !m_rr;
                // Crossed means a word leaves on the other-numbered output.
                if (eg[0])      m_ctrl = (d[0] != 0);
                else if (eg[1]) m_ctrl = (d[1] != 1);
                if (conf && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input bit v1, input logic [DATA_W-1:0] d1, input bit t1,
                            input bit v2, input logic [DATA_W-1:0] d2, input bit t2);
        in1_valid = v1; in1_data = d1; in1_dest = t1;
        in2_valid = v2; in2_data = d2; in2_dest = t2;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        rst_n      = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        drive_in(1, 4'hF, 0, 0, 4'h0, 0);

        // 1. reset: ready held low even with a request and empty slots
        tick();
        tick();
        check("t1_in1_ready_in_reset", in1_ready, 0);
        check("t1_out1_valid_in_reset", out1_valid, 0);
        rst_n = 1'b1;
        drive_in(0, 4'h0, 0, 0, 4'h0, 0);
        tick();
        check("t1_out1_valid", out1_valid, 0);
        check("t1_out2_valid", out2_valid, 0);
        check("t1_out1_data", out1_data, 0);
        check("t1_out2_data", out2_data, 0);
        check("t1_xbar_ctrl", xbar_ctrl, 0);

        // 2. straight traffic
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive_in(1, 4'hA, 0, 1, 4'h5, 1);
        #1;
        check("t2_in1_ready", in1_ready, 1);
        check("t2_in2_ready", in2_ready, 1);
        tick();
        check("t2_out1_data", out1_data, 4'hA);
        check("t2_out2_data", out2_data, 4'h5);
        check("t2_out1_valid", out1_valid, 1);
        check("t2_xbar_ctrl", xbar_ctrl, 0);

        // 3. crossed traffic
        drive_in(1, 4'hA, 1, 1, 4'h5, 0);
        tick();
        check("t3_out2_data", out2_data, 4'hA);
        check("t3_out1_data", out1_data, 4'h5);
        check("t3_xbar_ctrl", xbar_ctrl, 1);

        // 4. sustained conflict on out1: winners alternate 1,2,1,2
        drive_in(1, 4'h1, 0, 1, 4'h2, 0);
        #1;
        check("t4_in1_ready_first", in1_ready, 1);
        check("t4_in2_ready_first", in2_ready, 0);
        tick();
        check("t4_out1_data_0", out1_data, 4'h1);
        check("t4_in2_ready_second", in2_ready, 1);
        check("t4_in1_ready_second", in1_ready, 0);
        tick();
        check("t4_out1_data_1", out1_data, 4'h2);
        check("t4_xbar_ctrl", xbar_ctrl, 1);
        tick();
        check("t4_out1_data_2", out1_data, 4'h1);
        tick();
        check("t4_out1_data_3", out1_data, 4'h2);
`ifdef CROSSBAR_STATS_EN
        check("t4_conflict_cnt", conflict_cnt, 4);
`endif
        drive_in(0, 4'h0, 0, 0, 4'h0, 0);
        out1_ready = 1'b0;

        // 5. backpressure on a full out1
        drive_in(1, 4'h7, 0, 0, 4'h0, 0);
        #1;
        check("t5_in1_ready_blocked", in1_ready, 0);
        tick();
        tick();
        check("t5_out1_data_stable", out1_data, 4'h2);
        check("t5_out1_valid_held", out1_valid, 1);
        out1_ready = 1'b1;
        #1;
        check("t5_in1_ready_released", in1_ready, 1);
        tick();
        check("t5_out1_data_new", out1_data, 4'h7);
        drive_in(0, 4'h0, 0, 0, 4'h0, 0);

        // 6. reset mid-stream with out2 full
        out2_ready = 1'b0;
        drive_in(0, 4'h0, 0, 1, 4'h9, 1);
        tick();
        drive_in(0, 4'h0, 0, 0, 4'h0, 0);
        check("t6_out2_valid_full", out2_valid, 1);
        check("t6_out2_data_full", out2_data, 4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out2_valid_reset", out2_valid, 0);
        check("t6_out2_data_reset", out2_data, 0);
        tick();
        rst_n      = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive_in(1, 4'h3, 0, 1, 4'h4, 0);
        #1;
        check("t6_in1_wins_after_reset", in1_ready, 1);
        check("t6_in2_loses_after_reset", in2_ready, 0);
        tick();
        check("t6_out1_data", out1_data, 4'h3);
        drive_in(0, 4'h0, 0, 0, 4'h0, 0);
        tick();

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
